// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, overflow/underflow pulses and
// a selectable read mode (registered read or first-word-fall-through).
// Every output is a flop; flags are computed from the next occupancy so they
// change on the same edge as the count.
module sync_fifo_param #(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        Din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        Dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              empty_reg;
  logic              full_reg;
  logic              almost_full_reg;
  logic              almost_empty_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic [DATA_W-1:0] dout_reg;
  logic [DATA_W-1:0] dout_next;
  logic              wr_acc;
  logic              rd_acc;

  // Full and empty always block, regardless of a simultaneous opposite request.
  assign wr_acc      = wr_en && !full_reg;
  assign rd_acc      = rd_en && !empty_reg;
  assign rd_ptr_next = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  // Occupancy after this edge: up on write only, down on read only.
  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Keep the head word on Dout; when the word written this edge becomes
      // the head (FIFO empty after any pop) forward Din, since mem is not yet
      // updated.
      always_comb begin
        dout_next = dout_reg;
        if (count_next != '0) begin
          if (wr_acc && (wr_ptr_reg == rd_ptr_next)) begin
            dout_next = Din;
          end else begin
            dout_next = mem[rd_ptr_next];
          end
        end
      end
    end else begin : g_std
      // Present the popped word one cycle after the accepted read.
      always_comb begin
        dout_next = dout_reg;
        if (rd_acc) begin
          dout_next = mem[rd_ptr_reg];
        end
      end
    end
  endgenerate

  // Storage array; left without reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= Din;
    end
  end

  // Pointers, occupancy, registered flags, error pulses and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      dout_reg         <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == FULL_CNT);
      almost_full_reg  <= (count_next >= AF_CNT);
      almost_empty_reg <= (count_next <= AE_CNT);
      overflow_reg     <= wr_en && full_reg;
      underflow_reg    <= rd_en && empty_reg;
      dout_reg         <= dout_next;
    end
  end

  assign Dout         = dout_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives one stimulus stream into a standard-read and a
// FWFT instance side by side. The stimulus keeps a plain occupancy model and
// pushes expected words and per-edge flag records into scoreboard queues; a
// separate monitor pops and compares whenever the DUTs present data.
module tb_sync_fifo_param;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  typedef struct {
    int cnt;
    bit ov;
    bit uf;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] Din;
  logic              wr_en;
  logic              rd_en;

  logic [DATA_W-1:0] dout0, dout1;
  logic              empty0, empty1, full0, full1;
  logic              af0, af1, ae0, ae1, ov0, ov1, uf0, uf1;
  logic [3:0]        count0, count1;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .Din(Din), .wr_en(wr_en), .rd_en(rd_en),
    .Dout(dout0), .empty(empty0), .full(full0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(uf0)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .Din(Din), .wr_en(wr_en), .rd_en(rd_en),
    .Dout(dout1), .empty(empty1), .full(full1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(uf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_errors = 0;
  int                ref_cnt  = 0;
  logic [DATA_W-1:0] exp0[$];
  logic [DATA_W-1:0] exp1[$];
  exp_t              flag_q[$];
  logic [DATA_W-1:0] last0 = '0;
  logic [DATA_W-1:0] last1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] c, input logic f,
                             input logic e, input logic afl, input logic ael,
                             input logic o, input logic u, input exp_t x);
    chk({tag, "_count"}, 32'(c), x.cnt);
    chk({tag, "_full"}, 32'(f), 32'(x.cnt == DEPTH));
    chk({tag, "_empty"}, 32'(e), 32'(x.cnt == 0));
    chk({tag, "_almost_full"}, 32'(afl), 32'(x.cnt >= AF));
    chk({tag, "_almost_empty"}, 32'(ael), 32'(x.cnt <= AE));
    chk({tag, "_overflow"}, 32'(o), 32'(x.ov));
    chk({tag, "_underflow"}, 32'(u), 32'(x.uf));
  endtask

  task automatic check_reset(input string tag);
    exp_t z;
    z.cnt = 0;
    z.ov  = 1'b0;
    z.uf  = 1'b0;
    check_flags({tag, "_std"}, count0, full0, empty0, af0, ae0, ov0, uf0, z);
    check_flags({tag, "_fwft"}, count1, full1, empty1, af1, ae1, ov1, uf1, z);
    chk({tag, "_std_dout"}, 32'(dout0), 0);
    chk({tag, "_fwft_dout"}, 32'(dout1), 0);
  endtask

  // One clock of stimulus; the model decides acceptance from the occupancy
  // before the edge and records what the edge must produce.
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d);
    exp_t x;
    bit   acc_w;
    bit   acc_r;
    wr_en = w;
    rd_en = r;
    Din   = d;
    acc_w = w && (ref_cnt < DEPTH);
    acc_r = r && (ref_cnt > 0);
    if (acc_w) begin
      exp0.push_back(d);
      exp1.push_back(d);
    end
    ref_cnt = ref_cnt + int'(acc_w) - int'(acc_r);
    x.cnt = ref_cnt;
    x.ov  = w && !acc_w;
    x.uf  = r && !acc_r;
    flag_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Asserted away from any clock edge; outputs must already be at reset
  // values one time unit later.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp0.delete();
    exp1.delete();
    flag_q.delete();
    ref_cnt = 0;
    last0 = '0;
    last1 = '0;
    #1;
    check_reset(tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic drain();
    while (ref_cnt > 0) step(1'b0, 1'b1, '0);
  endtask

  task automatic fill();
    while (ref_cnt < DEPTH) step(1'b1, 1'b0, DATA_W'($urandom));
  endtask

  // Monitor: sample pre-edge state mid-cycle, compare just after the edge.
  initial begin : monitor
    logic              p_rst;
    logic              p_fire0;
    logic              p_fire1;
    exp_t              x;
    logic [DATA_W-1:0] w;
    forever begin
      @(negedge clk);
      p_rst   = rst;
      p_fire0 = rd_en && !empty0;
      p_fire1 = rd_en && !empty1;
      @(posedge clk);
      #1;
      if (p_rst && rst) begin
        if (flag_q.size() > 0) begin
          x = flag_q.pop_front();
          check_flags("std", count0, full0, empty0, af0, ae0, ov0, uf0, x);
          check_flags("fwft", count1, full1, empty1, af1, ae1, ov1, uf1, x);
        end
        if (p_fire0) begin
          if (exp0.size() == 0) begin
            chk("std_read_expected", 0, 1);
          end else begin
            w = exp0.pop_front();
            last0 = w;
            $display("read std  data=%03h count=%0d", w, count0);
          end
        end
        chk("std_dout", 32'(dout0), 32'(last0));
        if (p_fire1) begin
          if (exp1.size() == 0) chk("fwft_pop_expected", 0, 1);
          else void'(exp1.pop_front());
        end
        if (!empty1) begin
          if (exp1.size() == 0) chk("fwft_head_expected", 0, 1);
          else last1 = exp1[0];
        end
        chk("fwft_dout", 32'(dout1), 32'(last1));
      end
    end
  end

  int pw;
  int pr;

  initial begin : stim
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    Din   = '0;
    repeat (2) @(posedge clk);
    #2;
    check_reset("init");
    rst = 1'b1;

    // write 0..4 then four reads
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

    // eight writes, a rejected ninth, then read all back
    do_reset("t2");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DATA_W'(1023 - i));
    drain();

    // underflow while empty; read+write together while empty
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 10'h155);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // full with read+write together, then half-full streaming across wrap
    fill();
    step(1'b1, 1'b1, 10'h2AA);
    while (ref_cnt > DEPTH / 2) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DATA_W'($urandom));
    drain();

    // occupancy walk 0 -> 8 -> 0
    fill();
    drain();

    // FWFT fall-through of a single word, then mid-burst reset
    step(1'b1, 1'b0, DATA_W'(62));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2) == 1, DATA_W'($urandom));
    do_reset("mid");

    // randomized traffic, first biased toward filling, then toward draining
    for (int i = 0; i < 400; i++) begin
      pw = (i < 200) ? 70 : 35;
      pr = (i < 200) ? 40 : 70;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, DATA_W'($urandom));
    end
    drain();
    step(1'b0, 1'b0, '0);

    chk("std_words_left", 32'(exp0.size()), 0);
    chk("fwft_words_left", 32'(exp1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
